mesi_cache_ctrl: RTL

MESI_CACHE_CTRL -- requirements
Module: mesi_cache_ctrl

---
 rtl/mesi_pkg.sv | 11 +
 rtl/mesi_line_array.sv | 67 ++++++
 rtl/mesi_cache_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mesi_pkg.sv
// mesi_pkg: line-state, bus-command and controller-state encodings shared by the MESI cache.
package mesi_pkg;
   typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2, ST_E = 2'd3} line_state_t;
   typedef enum logic [1:0] {BUS_RD = 2'd0, BUS_RDX = 2'd1, BUS_UPGR = 2'd2, BUS_FLUSH = 2'd3} bus_cmd_t;
   typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, MISS_REQ, MISS_WAIT, RESP} fsm_t;
   function automatic line_state_t snoop_next(line_state_t s, bus_cmd_t c);
      return (c == BUS_RDX) ? ST_I :
             (c == BUS_RD && (s == ST_M || s == ST_E)) ? ST_S :
             (c == BUS_UPGR && s == ST_S) ? ST_I : s;
   endfunction
endpackage

// File: rtl/mesi_line_array.sv
// mesi_line_array: direct-mapped tag/state/data store with a lookup port, a snoop port and a write port.
// The lookup port shows the state after this cycle's snoop; a write in the same cycle lands after the snoop.
module mesi_line_array
   import mesi_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int LINES  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] lk_addr,
   output logic              lk_hit,
   output logic [1:0]        lk_state,
   output logic [DATA_W-1:0] lk_data,
   output logic [ADDR_W-1:0] lk_vaddr,
   input  logic              snoop_valid,
   input  logic [1:0]        snoop_cmd,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_hit,
   output logic              snoop_flush,
   output logic [DATA_W-1:0] snoop_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [1:0]        wr_state,
   input  logic [DATA_W-1:0] wr_data
);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;
   logic [TAG_W-1:0]  tags [LINES];
   logic [DATA_W-1:0] data [LINES];
   line_state_t       st   [LINES];
   logic [IDX_W-1:0]  s_idx, l_idx, w_idx;
   logic              s_match, s_flush;
   line_state_t       s_next, l_state;
   assign s_idx    = snoop_addr[IDX_W-1:0];
   assign l_idx    = lk_addr[IDX_W-1:0];
   assign w_idx    = wr_addr[IDX_W-1:0];
   assign s_match  = snoop_valid && st[s_idx] != ST_I && tags[s_idx] == snoop_addr[ADDR_W-1:IDX_W];
   assign s_next   = snoop_next(st[s_idx], bus_cmd_t'(snoop_cmd));
   assign s_flush  = s_match && st[s_idx] == ST_M && (snoop_cmd == BUS_RD || snoop_cmd == BUS_RDX);
   assign l_state  = (s_match && s_idx == l_idx) ? s_next : st[l_idx];
   assign lk_state = l_state;
   assign lk_hit   = l_state != ST_I && tags[l_idx] == lk_addr[ADDR_W-1:IDX_W];
   assign lk_data  = data[l_idx];
   assign lk_vaddr = {tags[l_idx], l_idx};
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) st[i] <= ST_I;
         snoop_hit   <= 1'b0;
         snoop_flush <= 1'b0;
         snoop_data  <= '0;
      end else begin
         snoop_hit   <= s_match;
         snoop_flush <= s_flush;
         snoop_data  <= s_flush ? data[s_idx] : '0;
         if (s_match) st[s_idx] <= s_next;
         if (wr_en) st[w_idx] <= line_state_t'(wr_state);
      end
   end
   always_ff @(posedge clock) begin
      if (wr_en) begin
         tags[w_idx] <= wr_addr[ADDR_W-1:IDX_W];
         data[w_idx] <= wr_data;
      end
   end
endmodule

// File: rtl/mesi_cache_ctrl.sv
// mesi_cache_ctrl: direct-mapped snooping cache controller (MSI; full MESI with MESI_EXCLUSIVE_EN defined).
module mesi_cache_ctrl
   import mesi_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int LINES  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              bus_req,
   output logic [1:0]        bus_cmd,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_grant,
   input  logic              bus_done,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_shared,
   input  logic              snoop_valid,
   input  logic [1:0]        snoop_cmd,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_hit,
   output logic              snoop_flush,
   output logic [DATA_W-1:0] snoop_data
);
   fsm_t              fsm;
   logic              wr_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic              lk_hit, accept, idle_wr, wb_done, fill, wr_en;
   logic [1:0]        lk_state, wr_state;
   logic [DATA_W-1:0] lk_data, fill_data, wr_data;
   logic [ADDR_W-1:0] lk_addr, lk_vaddr, wr_addr;
   line_state_t       rd_fill_state, fill_state;
`ifdef MESI_EXCLUSIVE_EN
   assign rd_fill_state = bus_shared ? ST_S : ST_E;
`else
   logic unused_shared;
   assign unused_shared = bus_shared;
   assign rd_fill_state = ST_S;
`endif
   assign accept     = req_valid && req_ready;
   assign lk_addr    = (fsm == IDLE) ? req_addr : addr_r;
   assign idle_wr    = accept && req_write && lk_hit && (lk_state == ST_M || lk_state == ST_E);
   assign wb_done    = fsm == WB_WAIT && bus_done;
   assign fill       = fsm == MISS_WAIT && bus_done;
   assign fill_state = wr_r ? ST_M : rd_fill_state;
   assign fill_data  = wr_r ? wdata_r : bus_rdata;
   assign wr_en      = idle_wr || wb_done || fill;
   assign wr_addr    = idle_wr ? req_addr : wb_done ? lk_vaddr : addr_r;
   assign wr_state   = idle_wr ? ST_M : wb_done ? ST_I : fill_state;
   assign wr_data    = idle_wr ? req_wdata : wb_done ? lk_data : fill_data;
   mesi_line_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES)) u_arr (
      .clock(clock), .reset(reset),
      .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_state(lk_state), .lk_data(lk_data), .lk_vaddr(lk_vaddr),
      .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
      .snoop_hit(snoop_hit), .snoop_flush(snoop_flush), .snoop_data(snoop_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_state(wr_state), .wr_data(wr_data)
   );
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm        <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         bus_req    <= 1'b0;
         bus_cmd    <= '0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         wr_r       <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (fsm)
            IDLE: if (accept) begin
               addr_r    <= req_addr;
               wr_r      <= req_write;
               wdata_r   <= req_wdata;
               req_ready <= 1'b0;
               if (lk_hit && (!req_write || lk_state != ST_S)) begin
                  resp_valid <= 1'b1;
                  resp_rdata <= req_write ? req_wdata : lk_data;
                  fsm        <= RESP;
               end else if (lk_hit) begin
                  bus_req  <= 1'b1;
                  bus_cmd  <= BUS_UPGR;
                  bus_addr <= req_addr;
                  fsm      <= MISS_REQ;
               end else if (lk_state == ST_M) begin
                  bus_req   <= 1'b1;
                  bus_cmd   <= BUS_FLUSH;
                  bus_addr  <= lk_vaddr;
                  bus_wdata <= lk_data;
                  fsm       <= WB_REQ;
               end else begin
                  bus_req  <= 1'b1;
                  bus_cmd  <= req_write ? BUS_RDX : BUS_RD;
                  bus_addr <= req_addr;
                  fsm      <= MISS_REQ;
               end
            end
            WB_REQ: if (bus_grant) begin
               bus_req <= 1'b0;
               fsm     <= WB_WAIT;
            end
            WB_WAIT: if (bus_done) begin
               bus_req  <= 1'b1;
               bus_cmd  <= wr_r ? BUS_RDX : BUS_RD;
               bus_addr <= addr_r;
               fsm      <= MISS_REQ;
            end
            // an upgrade whose S copy was snooped away must fetch the line instead
            MISS_REQ: if (bus_grant) begin
               bus_req <= 1'b0;
               fsm     <= MISS_WAIT;
            end else if (bus_cmd == BUS_UPGR && !lk_hit) begin
               bus_cmd <= BUS_RDX;
            end
            MISS_WAIT: if (bus_done) begin
               resp_valid <= 1'b1;
               resp_rdata <= fill_data;
               fsm        <= RESP;
            end
            RESP: begin
               req_ready <= 1'b1;
               fsm       <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end
endmodule
